// File: rtl/sr_seq_pkg.sv
// Shared types and helpers for the SR flip-flop write sequencer.
package sr_seq_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck
    } state_e;

    function automatic int unsigned calc_aw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_pulse_encoder.sv
// Combinational one-hot S/R encoder; the only place S/R bits are formed,
// so S and R can never be high together on any bit.
module sr_pulse_encoder
    import sr_seq_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = calc_aw(N)
) (
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  logic          data_i,
    output logic [N-1:0]  s_o,
    output logic [N-1:0]  r_o
);

    always_comb begin
        s_o = '0;
        r_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (en_i && (addr_i == AW'(i))) begin
                s_o[i] = data_i;
                r_o[i] = ~data_i;
            end
        end
    end

endmodule

// File: rtl/sr_write_sequencer.sv
// Accepts single-bit write requests, pulses S or R on the addressed flip-flop,
// waits a settle interval, reads Q back and retries on mismatch.
module sr_write_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned AW        = calc_aw(N)
) (
    input  logic          Clk,
    input  logic          MasterResetN,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [AW-1:0] ReqAddr,
    input  logic          ReqData,
    output logic [N-1:0]  S,
    output logic [N-1:0]  R,
    input  logic [N-1:0]  Q,
    output logic          Done,
    output logic          Err,
    output logic          Busy
);

    localparam int unsigned SW = calc_aw(SETTLE);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          data_q, data_d;
    logic [2:0]    retry_q, retry_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [N-1:0]  s_q, s_d, r_q, r_d;
    logic          done_q, done_d, err_q, err_d, busy_q;

    logic          accept, addr_ok;
    logic          pulse_en, pulse_data;
    logic [AW-1:0] pulse_addr;

    assign ReqReady = MasterResetN && (state_q == StIdle);
    assign accept   = ReqValid && ReqReady;
    assign addr_ok  = 32'(ReqAddr) < N;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        retry_d    = retry_q;
        settle_d   = settle_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pulse_en   = 1'b0;
        pulse_addr = addr_q;
        pulse_data = data_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = ReqAddr;
                    data_d = ReqData;
                    if (addr_ok) begin
                        // Pulse is registered on the accept edge, so it is
                        // launched here rather than from StDrive.
                        state_d    = StDrive;
                        retry_d    = '0;
                        pulse_en   = 1'b1;
                        pulse_addr = ReqAddr;
                        pulse_data = ReqData;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StDrive: begin
                state_d  = StSettle;
                settle_d = '0;
            end
            StSettle: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StCheck: begin
                // An unknown readback bit fails the equality and is retried.
                if (Q[addr_q] == data_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (retry_q < 3'(MAX_RETRY)) begin
                    retry_d  = retry_q + 3'd1;
                    state_d  = StDrive;
                    pulse_en = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    sr_pulse_encoder #(
        .N  (N),
        .AW (AW)
    ) u_encoder (
        .en_i   (pulse_en),
        .addr_i (pulse_addr),
        .data_i (pulse_data),
        .s_o    (s_d),
        .r_o    (r_d)
    );

    always_ff @(posedge Clk) begin
        if (!MasterResetN) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= 1'b0;
            retry_q  <= '0;
            settle_q <= '0;
            s_q      <= '0;
            r_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= (state_d != StIdle);
        end
    end

    assign S    = s_q;
    assign R    = r_q;
    assign Done = done_q;
    assign Err  = err_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_sr_write_sequencer.sv
// Bench for sr_write_sequencer: behavioural SR bank, randomized requests,
// scoreboard of expected completions checked by an independent monitor.
module tb_sr_write_sequencer;
    import sr_seq_pkg::*;

    localparam int unsigned TN      = 5;
    localparam int unsigned TSETTLE = 1;
    localparam int unsigned TRETRY  = 2;
    localparam int unsigned TAW     = calc_aw(TN);
    localparam int          PERIOD  = 2 + TSETTLE;
    localparam int          NRAND   = 200;

    typedef struct {
        int   acc;
        int   addr;
        logic data;
        logic bad;
        logic err;
        int   lat;
        int   att;
    } exp_t;

    logic           Clk          = 1'b0;
    logic           MasterResetN = 1'b0;
    logic           ReqValid     = 1'b0;
    logic           ReqReady;
    logic [TAW-1:0] ReqAddr      = '0;
    logic           ReqData      = 1'b0;
    logic [TN-1:0]  S, R, Q;
    logic           Done, Err, Busy;

    logic [TN-1:0]  bank    = '0;
    logic [TN-1:0]  stuck_m = '0;
    logic [TN-1:0]  stuck_v = '0;

    exp_t           sbq[$];
    int             edge_n     = 0;
    logic           rst_seen   = 1'b0;
    int             errors     = 0;
    int             checks     = 0;
    int             pulses     = 0;
    int             accepted   = 0;
    int             issued     = 0;
    int             stalls     = 0;
    logic [TN-1:0]  model_bank = '0;
    logic           drv_done   = 1'b0;
    logic           mon_done   = 1'b0;

    sr_write_sequencer #(
        .N         (TN),
        .SETTLE    (TSETTLE),
        .MAX_RETRY (TRETRY)
    ) u_dut (
        .Clk          (Clk),
        .MasterResetN (MasterResetN),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqAddr      (ReqAddr),
        .ReqData      (ReqData),
        .S            (S),
        .R            (R),
        .Q            (Q),
        .Done         (Done),
        .Err          (Err),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural SR bank; stuck bits override only the readback.
    always @(posedge Clk) begin
        for (int i = 0; i < TN; i++) begin
            if (S[i]) bank[i] <= 1'b1;
            else if (R[i]) bank[i] <= 1'b0;
        end
        edge_n   <= edge_n + 1;
        rst_seen <= MasterResetN;
    end

    assign Q = (bank & ~stuck_m) | (stuck_v & stuck_m);

    // Monitor: samples at negedge; edge_n is the index of the latest rising edge.
    initial begin
        exp_t          h;
        int            off;
        logic          exp_busy;
        logic          stuck_fail;
        logic [TN-1:0] oh;
        forever begin
            @(negedge Clk);
            if (!rst_seen) begin
                checks++;
                if (S != '0 || R != '0 || Done || Err || Busy) begin
                    errors++;
                    $display("FAIL reset_vals: got S=%b R=%b Done=%b Err=%b Busy=%b want all 0",
                             S, R, Done, Err, Busy);
                end
                if (!MasterResetN) begin
                    checks++;
                    if (ReqReady !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_ready: got %b want 0", ReqReady);
                    end
                end
                sbq.delete();
                pulses = 0;
            end else begin
                exp_busy = 1'b0;
                if (sbq.size() > 0) begin
                    h = sbq[0];
                    exp_busy = !h.bad && edge_n >= h.acc && edge_n < h.acc + h.lat;
                end
                checks++;
                if (Busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy: got %b want %b at edge %0d", Busy, exp_busy, edge_n);
                end
                checks++;
                if (ReqReady !== (MasterResetN && !exp_busy)) begin
                    errors++;
                    $display("FAIL ready: got %b want %b at edge %0d", ReqReady,
                             MasterResetN && !exp_busy, edge_n);
                end
                checks++;
                if ((S & R) != '0 || $countones(S | R) > 1) begin
                    errors++;
                    $display("FAIL sr_onehot: got S=%b R=%b want disjoint one-hot", S, R);
                end
                if ((S | R) != '0) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL stray_pulse: got S=%b R=%b want none", S, R);
                    end else begin
                        h   = sbq[0];
                        off = edge_n - h.acc;
                        oh  = '0;
                        if (!h.bad) oh[h.addr] = 1'b1;
                        if (h.bad || S != (h.data ? oh : '0) || R != (h.data ? '0 : oh) ||
                            off < 0 || off % PERIOD != 0 || off >= h.lat) begin
                            errors++;
                            $display("FAIL pulse: got S=%b R=%b offset=%0d want addr=%0d data=%b bad=%b",
                                     S, R, off, h.addr, h.data, h.bad);
                        end
                        pulses++;
                    end
                end
                if (Done || Err) begin
                    checks++;
                    if (Done && Err) begin
                        errors++;
                        $display("FAIL done_err: got both high want at most one");
                    end else if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL stray_done: got Done=%b Err=%b want no completion", Done, Err);
                    end else begin
                        h   = sbq.pop_front();
                        off = edge_n - h.acc;
                        if (Err != h.err || off != h.lat || pulses != h.att) begin
                            errors++;
                            $display("FAIL complete: got err=%b lat=%0d pulses=%0d want err=%b lat=%0d pulses=%0d",
                                     Err, off, pulses, h.err, h.lat, h.att);
                        end
                        if (Done) begin
                            checks++;
                            if (bank != model_bank) begin
                                errors++;
                                $display("FAIL bank: got %b want %b", bank, model_bank);
                            end
                        end
                    end
                    pulses = 0;
                end
                if (sbq.size() > 0 && edge_n > sbq[0].acc + sbq[0].lat) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout: got no completion by edge %0d want at %0d",
                             edge_n, sbq[0].acc + sbq[0].lat);
                    void'(sbq.pop_front());
                    pulses = 0;
                end
            end
            if (MasterResetN && ReqValid && ReqReady) begin
                h.acc  = edge_n + 1;
                h.addr = int'(ReqAddr);
                h.data = ReqData;
                h.bad  = h.addr >= TN;
                if (h.bad) begin
                    h.err = 1'b1;
                    h.lat = 0;
                    h.att = 0;
                end else begin
                    stuck_fail = stuck_m[h.addr] && (stuck_v[h.addr] != ReqData);
                    h.att = stuck_fail ? TRETRY + 1 : 1;
                    h.err = stuck_fail;
                    h.lat = h.att * PERIOD;
                    model_bank[h.addr] = ReqData;
                end
                sbq.push_back(h);
                accepted++;
            end
            if (drv_done && !mon_done) begin
                checks++;
                if (sbq.size() != 0) begin
                    errors++;
                    $display("FAIL drain: got %0d pending want 0", sbq.size());
                end
                checks++;
                if (accepted != issued || stalls != 0) begin
                    errors++;
                    $display("FAIL accept_count: got accepted=%0d stalls=%0d want %0d and 0",
                             accepted, stalls, issued);
                end
                mon_done = 1'b1;
            end
        end
    end

    task automatic send(input int a, input logic d);
        int n;
        ReqAddr  = TAW'(a);
        ReqData  = d;
        ReqValid = 1'b1;
        issued++;
        n = 0;
        @(negedge Clk);
        while (!ReqReady && n < 64) begin
            @(negedge Clk);
            n++;
        end
        if (!ReqReady) stalls++;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        ReqAddr  = TAW'($urandom);
        ReqData  = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            if (ReqReady && !Busy) break;
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int gap;
        repeat (3) @(posedge Clk);
        #1 MasterResetN = 1'b1;
        @(posedge Clk);
        #1;
        send(2, 1'b1);
        wait_idle();
        send(2, 1'b0);
        wait_idle();
        stuck_m[1] = 1'b1;
        stuck_v[1] = 1'b0;
        send(1, 1'b1);
        wait_idle();
        stuck_m = '0;
        send(5, 1'b1);
        send(7, 1'b0);
        send(0, 1'b1);
        wait_idle();
        // Reset lands in SETTLE; the aborted request must not complete.
        send(3, 1'b1);
        @(posedge Clk);
        #1 MasterResetN = 1'b0;
        @(posedge Clk);
        #1 MasterResetN = 1'b1;
        send(3, 1'b1);
        wait_idle();
        for (int n = 0; n < NRAND; n++) begin
            if (n % 25 == 0) begin
                wait_idle();
                stuck_m = TN'($urandom) & TN'($urandom);
                stuck_v = TN'($urandom);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge Clk);
                #1;
            end
            send($urandom_range(0, (1 << TAW) - 1), 1'($urandom));
        end
        wait_idle();
        repeat (2) @(posedge Clk);
        drv_done = 1'b1;
    end

    initial begin
        for (int i = 0; i < 20000 && !mon_done; i++) @(posedge Clk);
        if (!mon_done) begin
            $display("FAIL watchdog: got no end of test want completion within 20000 cycles");
            $fatal(1, "bench did not complete");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
